conv_window_gen: RTL and testbench

Sliding-window generator for the convolution datapath. Accepts a raster-order pixel stream, one pixel per beat, and buffers the previous K-1 image rows in enable-gated line buffers. Presents a K×K window, one per accepted pixel whose window lies fully inside the image, to the convolution engine downstream over a valid/ready handshake. Sits directly downstream of the pixel input stream and upstream of the MAC array.

---
 rtl/conv_window_gen_pkg.sv | 15 +
 rtl/conv_window_gen_line_buffer.sv | 26 ++
 rtl/conv_window_gen.sv | 124 ++++++++++++
 tb/tb_conv_window_gen.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_window_gen_pkg.sv
// Shared types and helpers for the sliding-window generator (conv_window_gen).
package conv_window_gen_pkg;

   typedef enum logic [1:0] {
      S_FILL,
      S_RUN,
      S_LAST
   } state_e;

   // Element index of window position (r,c); multiply by the pixel width for the bit offset.
   function automatic int win_idx(input int r, input int c, input int k);
      return r * k + c;
   endfunction

endpackage

// File: rtl/conv_window_gen_line_buffer.sv
// Enable-gated delay line of Length pixels; dout is the pixel written Length enables ago.
module line_buffer #(
   parameter int N      = 8,
   parameter int Length = 28
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en,
   input  logic [N-1:0] din,
   output logic [N-1:0] dout
);

   logic [N-1:0] mem [Length];

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < Length; i++) mem[i] <= '0;
      end else if (en) begin
         mem[0] <= din;
         for (int i = 1; i < Length; i++) mem[i] <= mem[i-1];
      end
   end

   assign dout = mem[Length-1];

endmodule

// File: rtl/conv_window_gen.sv
// K x K sliding-window generator over a raster pixel stream with valid/ready on both sides.
// Optional build macro CONV_WINDOW_GEN_STRIDE2_EN: emit only every second window in each dimension.
module conv_window_gen
   import conv_window_gen_pkg::*;
#(
   parameter int N         = 8,
   parameter int ImgWidth  = 28,
   parameter int ImgHeight = 28,
   parameter int K         = 3
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [N-1:0]     data_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [K*K*N-1:0] window_o,
   output logic             frame_done_o
);

   localparam int CW = (ImgWidth  > 1) ? $clog2(ImgWidth)  : 1;
   localparam int RW = (ImgHeight > 1) ? $clog2(ImgHeight) : 1;

   state_e         state_q, state_d;
   logic [CW-1:0]  col_q;
   logic [RW-1:0]  row_q;
   logic           accept, col_end, row_end, produce;
   logic [N-1:0]   lb_out [K-1];
   logic [N-1:0]   col_in [K];
   logic [N-1:0]   win_q  [K][K];

   assign ready_o = ready_i || !valid_o;
   assign accept  = valid_i && ready_o;
   assign col_end = (col_q == CW'(ImgWidth - 1));
   assign row_end = (row_q == RW'(ImgHeight - 1));

`ifdef CONV_WINDOW_GEN_STRIDE2_EN
   localparam logic KPar = ((K - 1) % 2) != 0;
   assign produce = accept && (state_q == S_RUN) && (col_q >= CW'(K - 1))
                    && (row_q[0] == KPar) && (col_q[0] == KPar);
`else
   assign produce = accept && (state_q == S_RUN) && (col_q >= CW'(K - 1));
`endif

   for (genvar j = 0; j < K - 1; j++) begin : g_lb
      logic [N-1:0] lb_in;
      if (j == 0) begin : g_head
         assign lb_in = data_i;
      end else begin : g_tail
         assign lb_in = lb_out[j-1];
      end
      line_buffer #(.N(N), .Length(ImgWidth)) u_lb (
         .clk_i (clk_i),
         .rst_i (rst_i),
         .en    (accept),
         .din   (lb_in),
         .dout  (lb_out[j])
      );
   end

   // Row 0 of the incoming column is the oldest line buffer, the bottom row is the live pixel.
   for (genvar r = 0; r < K; r++) begin : g_col
      if (r == K - 1) begin : g_live
         assign col_in[r] = data_i;
      end else begin : g_buf
         assign col_in[r] = lb_out[K-2-r];
      end
      for (genvar c = 0; c < K; c++) begin : g_flat
         assign window_o[win_idx(r, c, K)*N +: N] = win_q[r][c];
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++) win_q[r][c] <= '0;
      end else if (accept) begin
         for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
            win_q[r][K-1] <= col_in[r];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         col_q <= '0;
         row_q <= '0;
      end else if (accept) begin
         if (col_end) begin
            col_q <= '0;
            row_q <= row_end ? '0 : row_q + RW'(1);
         end else begin
            col_q <= col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= S_FILL;
      else        state_q <= state_d;
   end

   // S_LAST lasts one cycle whether or not a pixel arrives; that pixel is row 0 of the next frame.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FILL: if (accept && col_end && (row_q == RW'(K - 2))) state_d = S_RUN;
         S_RUN:  if (accept && col_end && row_end)               state_d = S_LAST;
         S_LAST: state_d = S_FILL;
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)        valid_o <= 1'b0;
      else if (produce)  valid_o <= 1'b1;
      else if (ready_i)  valid_o <= 1'b0;
   end

   assign frame_done_o = (state_q == S_LAST);

endmodule

// File: tb/tb_conv_window_gen.sv
// Scoreboard bench for conv_window_gen: expected windows are queued as pixels are accepted.
module tb_conv_window_gen;

   localparam int N = 8;
   localparam int K = 3;
`ifdef CONV_WINDOW_GEN_STRIDE2_EN
   localparam int W   = 5;
   localparam int H   = 5;
   localparam int WPF = ((W - K + 2) / 2) * ((H - K + 2) / 2);
`else
   localparam int W   = 4;
   localparam int H   = 4;
   localparam int WPF = (W - K + 1) * (H - K + 1);
`endif
   localparam int WB       = K * K * N;
   localparam int LastBase = (H - K) * W + (W - K);

   logic          clk_i = 1'b0;
   logic          rst_i, valid_i, ready_i;
   logic [N-1:0]  data_i;
   logic          ready_o, valid_o, frame_done_o;
   logic [WB-1:0] window_o;

   conv_window_gen #(.N(N), .ImgWidth(W), .ImgHeight(H), .K(K)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .data_i       (data_i),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .window_o     (window_o),
      .frame_done_o (frame_done_o)
   );

   always #5 clk_i = ~clk_i;

   int            n_assert = 0;
   int            n_fail   = 0;
   logic [WB-1:0] sb [$];
   logic [N-1:0]  img [H][W];
   int            mrow = 0, mcol = 0;
   logic          exp_valid = 1'b0, exp_fd = 1'b0;
   int            win_seen = 0, fd_seen = 0, capture_at = -1;
   logic [WB-1:0] captured = '0, last_pop = '0;

   function automatic logic [WB-1:0] pack_win(input int base);
      logic [WB-1:0] w = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++) w[(r*K+c)*N +: N] = N'(base + r * W + c);
      return w;
   endfunction

   function automatic logic [WB-1:0] model_win(input int row, input int col);
      logic [WB-1:0] w = '0;
      for (int r = 0; r < K; r++)
         for (int c = 0; c < K; c++) w[(r*K+c)*N +: N] = img[row-K+1+r][col-K+1+c];
      return w;
   endfunction

   function automatic bit model_prod(input int row, input int col);
      bit p = (row >= K - 1) && (col >= K - 1);
`ifdef CONV_WINDOW_GEN_STRIDE2_EN
      p = p && (((row - K + 1) % 2) == 0) && (((col - K + 1) % 2) == 0);
`endif
      return p;
   endfunction

   task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes at negedge, update the model after the rising edge.
   task automatic tick(output bit acc);
      bit            hs, rdy, prod, last;
      logic [N-1:0]  dat;
      logic [WB-1:0] wv;
      @(negedge clk_i);
      acc = valid_i && ready_o;
      rdy = ready_i;
      hs  = valid_o && ready_i;
      dat = data_i;
      wv  = window_o;
      check("valid_o", WB'(valid_o), WB'(exp_valid));
      check("ready_o", WB'(ready_o), WB'(rdy || !exp_valid));
      if (valid_o) begin
         if (sb.size() == 0) check("unexpected_window", WB'(valid_o), '0);
         else begin
            check("window", wv, sb[0]);
            if (hs) begin
               if (win_seen == capture_at) captured = wv;
               last_pop = wv;
               win_seen++;
               void'(sb.pop_front());
            end
         end
      end
      @(posedge clk_i);
      #1;
      prod = 1'b0;
      last = 1'b0;
      if (acc) begin
         img[mrow][mcol] = dat;
         prod = model_prod(mrow, mcol);
         if (prod) sb.push_back(model_win(mrow, mcol));
         last = (mrow == H - 1) && (mcol == W - 1);
         if (mcol == W - 1) begin
            mcol = 0;
            mrow = (mrow == H - 1) ? 0 : mrow + 1;
         end else mcol++;
      end
      exp_fd    = acc && last;
      exp_valid = prod ? 1'b1 : (rdy ? 1'b0 : exp_valid);
      check("frame_done", WB'(frame_done_o), WB'(exp_fd));
      if (frame_done_o) fd_seen++;
   endtask

   task automatic send_pixel(input int d);
      bit acc = 1'b0;
      int n   = 0;
      valid_i = 1'b1;
      data_i  = N'(d);
      do begin
         tick(acc);
         n++;
      end while (!acc && n < 50);
      if (!acc) begin
         n_assert++;
         n_fail++;
         $error("FAIL accept_timeout observed=no_accept expected=accept");
      end
      valid_i = 1'b0;
   endtask

   task automatic idle(input int n);
      bit acc;
      valid_i = 1'b0;
      repeat (n) tick(acc);
   endtask

   task automatic send_frame(input int base, input int gap_max);
      for (int p = 0; p < W * H; p++) begin
         if (gap_max > 0) idle($urandom_range(gap_max, 0));
         send_pixel(base + p);
      end
   endtask

   initial begin
      int            s, f, p;
      bit            acc;
      logic [WB-1:0] held;

      rst_i   = 1'b0;
      valid_i = 1'b0;
      ready_i = 1'b1;
      data_i  = '0;
      repeat (2) @(posedge clk_i);
      #1;
      check("reset_valid", WB'(valid_o), '0);
      check("reset_window", window_o, '0);
      check("reset_done", WB'(frame_done_o), '0);
      rst_i = 1'b1;

      $display("[TB] continuous frame");
      s = win_seen;
      f = fd_seen;
      capture_at = s;
      send_frame(0, 0);
      idle(3);
      check("first_window", captured, pack_win(0));
      check("last_window", last_pop, pack_win(LastBase));
      check("win_count", WB'(win_seen - s), WB'(WPF));
      check("done_count", WB'(fd_seen - f), WB'(1));

      $display("[TB] downstream stall");
      s = win_seen;
      p = 0;
      while (!valid_o && p < W * H) begin
         send_pixel(p);
         p++;
      end
      held    = window_o;
      valid_i = 1'b1;
      data_i  = N'(p);
      ready_i = 1'b0;
      repeat (3) begin
         tick(acc);
         check("stall_no_accept", WB'(acc), '0);
         check("stall_hold", window_o, held);
      end
      ready_i = 1'b1;
      for (; p < W * H; p++) send_pixel(p);
      idle(3);
      check("stall_win_count", WB'(win_seen - s), WB'(WPF));

      $display("[TB] random input gaps");
      s = win_seen;
      send_frame(0, 3);
      idle(3);
      check("gap_win_count", WB'(win_seen - s), WB'(WPF));
      check("gap_last_window", last_pop, pack_win(LastBase));

      $display("[TB] back-to-back frames");
      s = win_seen;
      f = fd_seen;
      capture_at = s + WPF;
      send_frame(0, 0);
      send_frame(100, 0);
      idle(3);
      check("frame2_first_window", captured, pack_win(100));
      check("b2b_win_count", WB'(win_seen - s), WB'(2 * WPF));
      check("b2b_done_count", WB'(fd_seen - f), WB'(2));

      $display("[TB] reset mid-frame");
      for (int i = 0; i < 10; i++) send_pixel(i);
      rst_i = 1'b0;
      #1;
      check("midreset_valid", WB'(valid_o), '0);
      check("midreset_window", window_o, '0);
      check("midreset_done", WB'(frame_done_o), '0);
      repeat (2) @(posedge clk_i);
      #1;
      check("midreset_window_hold", window_o, '0);
      sb.delete();
      mrow      = 0;
      mcol      = 0;
      exp_valid = 1'b0;
      exp_fd    = 1'b0;
      rst_i     = 1'b1;
      s = win_seen;
      capture_at = s;
      send_frame(0, 0);
      idle(3);
      check("post_reset_first", captured, pack_win(0));
      check("post_reset_win_count", WB'(win_seen - s), WB'(WPF));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
